// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - ctrl_state_e   : controller state (normal running / waiting to redirect)
//   - MD_CYCLES_DEF  : default mul/div latency after the start is accepted
//   - EXC_VECTOR_DEF : default general exception entry PC
//   - selectTarget   : picks the redirect target, eret taking priority
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } ctrl_state_e;

  localparam int          MD_CYCLES_DEF  = 33;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // An eret returns to EPC; any other MEM-stage redirect is an exception
  // and goes to the vector. When both are raised, eret wins.
  function automatic logic [31:0] selectTarget(input logic        eret,
                                               input logic [31:0] epc,
                                               input logic [31:0] vec);
    return eret ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// md_busy_cnt
// Down-counter that tracks how long the multi-cycle mul/div unit is busy.
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-high reset
//   load_i    in  a mul/div start was accepted this cycle
//   md_busy_o out counter is nonzero (unit still producing HI/LO)
module md_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic md_busy_o
);

  localparam int            CW       = $clog2(MD_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // A newly accepted start always reloads the full latency; otherwise the
  // counter drains to zero and sits there. A flush does not touch it, since
  // a running operation belongs to an older instruction that must finish.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  // Counter register; synchronous reset clears any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign md_busy_o = (count_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for the five pipeline registers (pc, IF_ID,
// ID_EX, EX_MEM, MEM_WB). Turns load-use, HI/LO-vs-mul/div, cache-miss and
// MEM-stage exception/eret events into per-stage write enables and bubbles,
// and holds a pending redirect while the I-cache cannot take a new PC.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ID_RS/ID_RT/ID_UseRS/ID_UseRT   ID source registers and their use flags
//   ID_RHLRd, ID_start              ID reads HI/LO, ID is a mul/div
//   EX_DMRd, EX_RD, EX_start        EX is a load, its destination, mul/div start
//   MEM_Exception, MEM_eret_flush   MEM-stage redirect requests
//   CP0_EPC                         eret return address
//   icache_busy, dcache_busy        cache not ready
//   PC_Wr..MEM_WBWr                 pipeline register write enables
//   IF_Flush..MEM_Flush             pipeline register bubble inserts
//   redirect_valid, redirect_pc     NPC mux select and target
//   md_busy                         mul/div still running
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MD_CYCLES  = MD_CYCLES_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_UseRS,
  input  logic        ID_UseRT,
  input  logic        ID_RHLRd,
  input  logic        ID_start,
  input  logic        EX_DMRd,
  input  logic [4:0]  EX_RD,
  input  logic        EX_start,
  input  logic        MEM_Exception,
  input  logic        MEM_eret_flush,
  input  logic [31:0] CP0_EPC,
  input  logic        icache_busy,
  input  logic        dcache_busy,
  output logic        PC_Wr,
  output logic        IF_IDWr,
  output logic        ID_EXWr,
  output logic        EX_MEMWr,
  output logic        MEM_WBWr,
  output logic        IF_Flush,
  output logic        ID_Flush,
  output logic        EX_Flush,
  output logic        MEM_Flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        md_busy
);

  ctrl_state_e state_q, state_d;
  logic [31:0] redirectPc_q, redirectPc_d;

  logic        loadUse, mdHaz;
  logic        sMem, sEx, sId, sIf;
  logic        excReq;
  logic [31:0] excTarget;
  logic        mdBusyRaw, mdLoad;

  // Hazard detection and the stall chain. A stall in a stage holds every
  // stage above it, so each stall term includes the one below it.
  always_comb begin
    loadUse = EX_DMRd && (EX_RD != 5'd0) &&
              ((ID_UseRS && (ID_RS == EX_RD)) || (ID_UseRT && (ID_RT == EX_RD)));
    mdHaz   = md_busy && (ID_RHLRd || ID_start);
    sMem    = dcache_busy;
    sEx     = sMem;
    sId     = sEx || loadUse || mdHaz;
    sIf     = sId || icache_busy;
  end

  // Exception/eret requests only count while running; in REDIR the pipeline
  // has already been emptied, so anything left in MEM is stale.
  assign excReq    = (state_q == RUN) && (MEM_Exception || MEM_eret_flush);
  assign excTarget = selectTarget(MEM_eret_flush, CP0_EPC, EXC_VECTOR);

  // State and latched-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      redirectPc_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      redirectPc_q <= redirectPc_d;
    end
  end

  // Next state: a redirect that the I-cache cannot accept right now is
  // parked in REDIR with its target latched, and released on the first
  // cycle the I-cache is free.
  always_comb begin
    state_d      = state_q;
    redirectPc_d = redirectPc_q;
    unique case (state_q)
      RUN: begin
        if (excReq && icache_busy) begin
          state_d      = REDIR;
          redirectPc_d = excTarget;
        end
      end
      REDIR: begin
        if (!icache_busy) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs. Reset freezes and bubbles everything. Redirects override every
  // hazard (including a D-cache miss, whose access is squashed upstream) and
  // bubble all stages; only the pc write waits on the I-cache. Otherwise the
  // oldest stalled stage gets a bubble behind it while stages above hold.
  always_comb begin
    PC_Wr          = 1'b1;
    IF_IDWr        = 1'b1;
    ID_EXWr        = 1'b1;
    EX_MEMWr       = 1'b1;
    MEM_WBWr       = 1'b1;
    IF_Flush       = 1'b0;
    ID_Flush       = 1'b0;
    EX_Flush       = 1'b0;
    MEM_Flush      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = redirectPc_q;
    if (rst) begin
      PC_Wr     = 1'b0;
      IF_IDWr   = 1'b0;
      ID_EXWr   = 1'b0;
      EX_MEMWr  = 1'b0;
      MEM_WBWr  = 1'b0;
      IF_Flush  = 1'b1;
      ID_Flush  = 1'b1;
      EX_Flush  = 1'b1;
      MEM_Flush = 1'b1;
    end else if ((state_q == REDIR) || excReq) begin
      IF_Flush       = 1'b1;
      ID_Flush       = 1'b1;
      EX_Flush       = 1'b1;
      MEM_Flush      = 1'b1;
      PC_Wr          = !icache_busy;
      redirect_valid = !icache_busy;
      if (state_q == RUN) begin
        redirect_pc = excTarget;
      end
    end else begin
      PC_Wr     = !sIf;
      IF_IDWr   = !sId;
      IF_Flush  = sIf && !sId;
      ID_EXWr   = !sEx;
      ID_Flush  = sId && !sEx;
      EX_MEMWr  = !sMem;
      EX_Flush  = sEx && !sMem;
      MEM_Flush = sMem;
    end
  end

  // A start in the same cycle as a redirect belongs to a younger, squashed
  // instruction and must not launch the unit.
  assign mdLoad  = EX_start && EX_MEMWr && !excReq;
  assign md_busy = mdBusyRaw && !rst;

  md_busy_cnt #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_busy_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (mdLoad),
    .md_busy_o(mdBusyRaw)
  );

endmodule
